// File: rtl/irrigation_zone_sequencer.sv
// irrigation_zone_sequencer: round-robin zone server with valve dead time, bounded run and fault latch
module irrigation_zone_sequencer #(
  parameter int ZONES         = 4,
  parameter int RUN_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     tank_ok_i,
  input  logic [ZONES-1:0]         request_i,
  input  logic [ZONES-1:0]         mode_i,
  output logic [ZONES-1:0]         valve_o,
  output logic                     splinker_on_o,
  output logic                     dripper_on_o,
  output logic [1:0]               irrigation_encoded_o,
  output logic [$clog2(ZONES)-1:0] active_zone_o,
  output logic                     busy_o
);
  localparam int ZW = $clog2(ZONES);
  localparam int MC = RUN_CYCLES > SETTLE_CYCLES ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MC + 1);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2, FAULT = 2'd3;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
  logic [1:0]    state_q, state_d;
  logic [ZW-1:0] ptr_q, ptr_d, zone_q, zone_d, sel;
  logic          mode_q, mode_d, hit, run;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ZW:0]   sum, idx;
  // walk backwards from the farthest candidate so the nearest requester after the pointer wins
  always_comb begin
    hit = 1'b0;
    sel = '0;
    sum = '0;
    idx = '0;
    for (int i = ZONES; i >= 1; i--) begin
      sum = {1'b0, ptr_q} + (ZW+1)'(i);
      idx = sum >= (ZW+1)'(ZONES) ? sum - (ZW+1)'(ZONES) : sum;
      if (request_i[idx[ZW-1:0]]) begin
        hit = 1'b1;
        sel = idx[ZW-1:0];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    zone_d  = zone_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE:
        if (enable_i && tank_ok_i && hit) begin
          state_d = SETTLE;
          cnt_d   = '0;
          ptr_d   = sel;
          zone_d  = sel;
          mode_d  = mode_i[sel];
        end
      SETTLE, RUN:
        if (!tank_ok_i) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else if (!enable_i || !request_i[zone_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == (state_q == SETTLE ? SET_LAST : RUN_LAST)) begin
          state_d = state_q == SETTLE ? RUN : IDLE;
          cnt_d   = '0;
        end else
          cnt_d = cnt_q + CW'(1);
      default:
        if (tank_ok_i && !enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= ZW'(ZONES - 1);
      zone_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      zone_q  <= zone_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end
  assign run                  = state_q == RUN;
  assign valve_o              = run ? {{(ZONES-1){1'b0}}, 1'b1} << zone_q : '0;
  assign splinker_on_o        = run & mode_q;
  assign dripper_on_o         = run & ~mode_q;
  assign irrigation_encoded_o = run ? {1'b1, mode_q} : {1'b0, state_q == FAULT};
  assign active_zone_o        = zone_q;
  assign busy_o               = run || state_q == SETTLE;
endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// tb_irrigation_zone_sequencer: cycle vectors with hand-derived expectations, checked through a scoreboard queue
module tb_irrigation_zone_sequencer;
  logic clk = 1'b0, rst, en, tank;
  logic [3:0] req, mode, valve;
  logic [1:0] enc, zone;
  logic spl, drip, busy;
  always #5 clk = ~clk;
  irrigation_zone_sequencer #(.ZONES(4), .RUN_CYCLES(8), .SETTLE_CYCLES(2)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .tank_ok_i(tank),
    .request_i(req), .mode_i(mode), .valve_o(valve), .splinker_on_o(spl),
    .dripper_on_o(drip), .irrigation_encoded_o(enc), .active_zone_o(zone), .busy_o(busy)
  );
  typedef struct {
    logic rst, en, tank;
    logic [3:0] req, mode, valve;
    logic [1:0] enc;
    logic busy;
    logic [1:0] zone;
    int tag;
  } vec_t;
  vec_t vecs[$];
  logic [10:0] sb[$];
  logic c_rst, c_en, c_tank;
  logic [3:0] c_req, c_mode;
  int tag, tests = 0, fails = 0;
  task automatic exp_n(input logic [3:0] v, input logic [1:0] e, input logic b, input logic [1:0] z, input int n);
    vec_t r;
    r.rst = c_rst; r.en = c_en; r.tank = c_tank; r.req = c_req; r.mode = c_mode;
    r.valve = v; r.enc = e; r.busy = b; r.zone = z; r.tag = tag;
    repeat (n) vecs.push_back(r);
  endtask
  task automatic e_idle(input logic [1:0] z, input int n);   exp_n(4'b0, 2'b00, 1'b0, z, n); endtask
  task automatic e_settle(input logic [1:0] z, input int n); exp_n(4'b0, 2'b00, 1'b1, z, n); endtask
  task automatic e_fault(input logic [1:0] z, input int n);  exp_n(4'b0, 2'b01, 1'b0, z, n); endtask
  task automatic e_run(input logic [1:0] z, input logic m, input int n);
    logic [3:0] v;
    v = 4'b0001 << z;
    exp_n(v, {1'b1, m}, 1'b1, z, n);
  endtask
  task automatic set_in(input logic r, input logic e, input logic t, input logic [3:0] q, input logic [3:0] m);
    c_rst = r; c_en = e; c_tank = t; c_req = q; c_mode = m;
  endtask
  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: vector run did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    rst = 1'b1; en = 1'b0; tank = 1'b0; req = '0; mode = '0;
    @(posedge clk);
    #1;
    tests++;
    if ({valve, enc, busy, zone, spl, drip} !== 11'b0) begin
      fails++;
      $display("FAIL reset state: valve=%b enc=%b busy=%b zone=%0d spl=%b drip=%b", valve, enc, busy, zone, spl, drip);
    end
    tag = 1;
    set_in(1, 0, 0, 4'b0000, 4'b0000); e_idle(0, 1);
    set_in(0, 1, 1, 4'b0101, 4'b0001);
    e_settle(0, 2); e_run(0, 1, 8); e_idle(0, 1); e_settle(2, 2); e_run(2, 0, 8); e_idle(2, 1);
    tag = 2;
    c_req = 4'b1000; e_settle(3, 2); e_run(3, 0, 8); e_idle(3, 1);
    c_req = 4'b1001; e_settle(0, 2); e_run(0, 1, 8); e_idle(0, 1); e_settle(3, 2); e_run(3, 0, 1);
    tag = 3;
    set_in(1, 1, 1, 4'b0010, 4'b0000); e_idle(0, 1);
    c_rst = 0; e_settle(1, 2); e_run(1, 0, 4);
    c_req = 4'b0000; e_idle(1, 1);
    c_req = 4'b0111; e_settle(2, 1);
    tag = 4;
    c_tank = 0; e_fault(2, 1);
    c_tank = 1; e_fault(2, 2);
    c_en = 0; e_idle(2, 2);
    c_en = 1; c_tank = 0; e_idle(2, 2);
    tag = 5;
    set_in(1, 1, 1, 4'b0001, 4'b0001); e_idle(0, 1);
    c_rst = 0; e_settle(0, 1);
    c_mode = 4'b0000; e_settle(0, 1); e_run(0, 1, 8);
    c_tank = 0; c_req = 4'b0000; e_fault(0, 1);
    c_en = 0; c_tank = 1; e_idle(0, 1);
    tag = 6;
    set_in(0, 1, 1, 4'b0110, 4'b0000); e_settle(1, 2); e_run(1, 0, 3);
    c_rst = 1; e_idle(0, 1);
    c_rst = 0; e_settle(1, 1);
    for (int k = 0; k < vecs.size(); k++) begin
      logic [10:0] want, got;
      @(negedge clk);
      rst = vecs[k].rst; en = vecs[k].en; tank = vecs[k].tank;
      req = vecs[k].req; mode = vecs[k].mode;
      sb.push_back({vecs[k].valve, vecs[k].enc, vecs[k].busy, vecs[k].zone,
                    vecs[k].enc == 2'b11, vecs[k].enc == 2'b10});
      @(posedge clk);
      #1;
      want = sb.pop_front();
      got = {valve, enc, busy, zone, spl, drip};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL vec%0d test%0d: got valve=%b enc=%b busy=%b zone=%0d spl=%b drip=%b, want valve=%b enc=%b busy=%b zone=%0d spl=%b drip=%b",
                 k, vecs[k].tag, got[10:7], got[6:5], got[4], got[3:2], got[1], got[0],
                 want[10:7], want[6:5], want[4], want[3:2], want[1], want[0]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
